// File: rtl/rr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkt_arbiter
// Description : Round-robin packet arbiter. A requester that wins keeps the
//               grant (LOCK) until it sends a beat flagged last, it reaches
//               MAX_BEATS transferred beats, or it drops its request. The
//               grant is then released for one idle cycle, and the round-robin
//               pointer moves past the released requester.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               req      - [N] per-requester request (held while beats pending)
//               last     - [N] per-requester end-of-packet, used on xfer only
//               out_rdy  - downstream accepts the current beat
//               gnt      - [N] registered one-hot grant, zero when idle
//               gnt_idx  - [IW] registered index of the granted requester
//               gnt_vld  - registered, high while a grant is held
//               xfer     - combinational, one beat moves this cycle
//               ptr      - [IW] registered round-robin start index
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pkt_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 16,
    parameter int IW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  last,
    input  logic          out_rdy,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld,
    output logic          xfer,
    output logic [IW-1:0] ptr
);

    // The final beat a grant may carry is reached when the counter holds this.
    localparam logic [7:0] c_last_beat = 8'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;

    logic [IW-1:0] w_win_hi;
    logic [IW-1:0] w_win_any;
    logic          w_hi_found;
    logic [IW-1:0] w_win;
    logic          w_xfer;
    logic          w_release;

    // ------------------------------------------------------------------------
    // Winner search. Scanning from the top down lets the lowest qualifying
    // index overwrite earlier hits; w_win_hi only accepts indices at or above
    // the pointer, w_win_any is the wrap-around fallback.
    // ------------------------------------------------------------------------
    always_comb begin
        w_win_hi   = '0;
        w_win_any  = '0;
        w_hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_any = IW'(i);
                if (IW'(i) >= r_ptr) begin
                    w_win_hi   = IW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_win = w_hi_found ? w_win_hi : w_win_any;
    end

    // Reset gating keeps xfer quiet while rst is asserted, even if a grant
    // was still being held when reset arrived.
    assign w_xfer = (r_state == S_LOCK) & req[r_idx] & out_rdy & ~rst;

    // A single release covers any mix of last, beat limit and withdrawal.
    assign w_release = (w_xfer & last[r_idx])
                     | (w_xfer & (r_cnt == c_last_beat))
                     | ~req[r_idx];

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt       = S_LOCK;
                    w_gnt_nxt         = '0;
                    w_gnt_nxt[w_win]  = 1'b1;
                    w_idx_nxt         = w_win;
                    w_cnt_nxt         = '0;
                end
            end
            S_LOCK: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ptr_nxt   = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
                end else if (w_xfer && (r_cnt != 8'hFF)) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;
    assign gnt_vld = (r_state == S_LOCK);
    assign xfer    = w_xfer;
    assign ptr     = r_ptr;

endmodule
`default_nettype wire
